// File: rtl/ecc_scalar_mul_ctrl.sv
// Scalar-multiplication sequencer: R = k*G by left-to-right double-and-add over an en/done point ALU.
// Latency: KW scan cycles + calls*(ALU latency + 1) + 1 finish cycle; k=0 or k=1 makes no ALU calls.
// Backpressure: start is dropped while busy; each ALU request waits for alu_done or aborts after TIMEOUT wait cycles.
module ecc_scalar_mul_ctrl #(
    parameter int         KW      = 8,
    parameter logic [1:0] OP_ADD  = 2'd0,
    parameter logic [1:0] OP_DBL  = 2'd2,
    parameter int         TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [128:0]  G,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [128:0]  R_out,
    output logic          alu_en,
    output logic [128:0]  alu_P,
    output logic [128:0]  alu_Q,
    output logic [1:0]    alu_op,
    input  logic [128:0]  alu_R,
    input  logic          alu_done
);

    localparam int IW = (KW > 1) ? $clog2(KW) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // tcnt holds the number of wait cycles already spent before the current one
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [128:0]  INF   = {1'b1, 128'd0};

    typedef enum logic [2:0] {
        IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, FINISH
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] kr, kr_nxt;
    logic [128:0]  gr, gr_nxt;
    logic [128:0]  racc, racc_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          terr, terr_nxt;
    logic [128:0]  r_out_nxt, p_nxt, q_nxt;
    logic [1:0]    op_nxt;
    logic          adv, tmo;

    // Status and request strobes are pure state decodes, so reset clears them immediately
    assign busy   = (state != IDLE);
    assign done   = (state == FINISH);
    assign err    = (state == FINISH) && terr;
    assign alu_en = (state == DBL_REQ) || (state == ADD_REQ);

    // State, datapath and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            kr     <= '0;
            gr     <= '0;
            racc   <= INF;
            idx    <= '0;
            tcnt   <= '0;
            terr   <= 1'b0;
            R_out  <= INF;
            alu_P  <= '0;
            alu_Q  <= '0;
            alu_op <= '0;
        end else begin
            state  <= state_nxt;
            kr     <= kr_nxt;
            gr     <= gr_nxt;
            racc   <= racc_nxt;
            idx    <= idx_nxt;
            tcnt   <= tcnt_nxt;
            terr   <= terr_nxt;
            R_out  <= r_out_nxt;
            alu_P  <= p_nxt;
            alu_Q  <= q_nxt;
            alu_op <= op_nxt;
        end
    end

    // Next-state and datapath updates; operands load only when entering a request state
    always_comb begin
        state_nxt = state;
        kr_nxt    = kr;
        gr_nxt    = gr;
        racc_nxt  = racc;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        terr_nxt  = terr;
        r_out_nxt = R_out;
        p_nxt     = alu_P;
        q_nxt     = alu_Q;
        op_nxt    = alu_op;
        adv       = 1'b0;
        tmo       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    kr_nxt    = k;
                    gr_nxt    = G;
                    idx_nxt   = IW'(KW - 1);
                    racc_nxt  = INF;
                    terr_nxt  = 1'b0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (racc[128]) begin
                    // Still at infinity: leading zeros cost no ALU call, first one just loads G
                    if (kr[idx]) racc_nxt = gr;
                    adv = 1'b1;
                end else begin
                    p_nxt     = racc;
                    q_nxt     = racc;
                    op_nxt    = OP_DBL;
                    state_nxt = DBL_REQ;
                end
            end
            DBL_REQ: begin
                tcnt_nxt  = '0;
                state_nxt = DBL_WAIT;
            end
            DBL_WAIT: begin
                if (alu_done) begin
                    racc_nxt = alu_R;
                    if (kr[idx]) begin
                        p_nxt     = alu_R;
                        q_nxt     = gr;
                        op_nxt    = OP_ADD;
                        state_nxt = ADD_REQ;
                    end else begin
                        adv = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
                    tmo = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ADD_REQ: begin
                tcnt_nxt  = '0;
                state_nxt = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (alu_done) begin
                    racc_nxt = alu_R;
                    adv      = 1'b1;
                end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
                    tmo = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (adv) begin
            if (idx == '0) begin
                r_out_nxt = racc_nxt;
                state_nxt = FINISH;
            end else begin
                idx_nxt   = idx - 1'b1;
                state_nxt = SCAN;
            end
        end

        if (tmo) begin
            racc_nxt  = INF;
            r_out_nxt = INF;
            terr_nxt  = 1'b1;
            state_nxt = FINISH;
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Bench for the scalar-multiplication sequencer against a toy additive-group ALU with latency 3.
// Latency: checked per scenario against the expected double-and-add call pattern.
// Backpressure: the ALU model can be muted to exercise the wait timeout.
module tb_ecc_scalar_mul_ctrl;

    localparam int         KW      = 8;
    localparam int         TIMEOUT = 16;
    localparam int         L       = 3;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_DBL  = 2'd2;
    localparam logic [128:0] INF   = {1'b1, 128'd0};

    logic          clk, rst_n, start;
    logic [KW-1:0] k;
    logic [128:0]  G;
    logic          busy, done, err, alu_en, alu_done;
    logic [128:0]  R_out, alu_P, alu_Q, alu_R;
    logic [1:0]    alu_op;

    int total = 0;
    int bad   = 0;
    int cyc_now = 0;
    int first_en_cyc;
    logic [1:0] op_log[$];
    bit mute = 0;
    bit force_done = 0;

    ecc_scalar_mul_ctrl #(.KW(KW), .OP_ADD(OP_ADD), .OP_DBL(OP_DBL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k(k), .G(G),
        .busy(busy), .done(done), .err(err), .R_out(R_out),
        .alu_en(alu_en), .alu_P(alu_P), .alu_Q(alu_Q), .alu_op(alu_op),
        .alu_R(alu_R), .alu_done(alu_done)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    function automatic logic [128:0] mkpt(input logic [63:0] x, input logic [63:0] y);
        return {1'b0, x, y};
    endfunction

    // Toy group: points add coordinate-wise, infinity is the identity
    function automatic logic [128:0] alu_fn(input logic [1:0] op, input logic [128:0] p, input logic [128:0] q);
        logic [128:0] rhs;
        rhs = (op == OP_DBL) ? p : q;
        if (p[128]) return rhs;
        if (rhs[128]) return p;
        return mkpt(p[127:64] + rhs[127:64], p[63:0] + rhs[63:0]);
    endfunction

    // Reference: k*G in the toy group is just k times each coordinate
    function automatic logic [128:0] ref_mul(input logic [KW-1:0] kk, input logic [128:0] g);
        logic [63:0] km;
        km = 64'(kk);
        if (kk == 0) return INF;
        return mkpt(km * g[127:64], km * g[63:0]);
    endfunction

    function automatic int ref_calls(input logic [KW-1:0] kk);
        int m, pc;
        m = -1; pc = 0;
        for (int i = 0; i < KW; i++) if (kk[i]) begin m = i; pc++; end
        return (m < 0) ? 0 : m + pc - 1;
    endfunction

    // Bench ALU: answers L cycles after each alu_en, checks operand stability while waiting
    initial begin
        bit           pend, orphan;
        int           cnt;
        logic [128:0] rp, rq, res;
        logic [1:0]   rop;
        pend = 0; orphan = 0; cnt = 0;
        alu_done = 0; alu_R = '0;
        forever begin
            @(posedge clk); #1;
            alu_done = 0;
            if (force_done) begin
                alu_done = 1;
                force_done = 0;
            end
            if (!rst_n) orphan = 1;
            if (pend) begin
                if (!orphan) begin
                    total++;
                    if (alu_P !== rp || alu_Q !== rq || alu_op !== rop) begin
                        bad++;
                        $display("FAIL operand_stable: got op=%0d P=%h Q=%h want op=%0d P=%h Q=%h",
                                 alu_op, alu_P, alu_Q, rop, rp, rq);
                    end
                end
                cnt--;
                if (cnt == 0) begin
                    alu_done = 1;
                    alu_R = res;
                    pend = 0;
                end
            end
            if (alu_en && rst_n) begin
                op_log.push_back(alu_op);
                if (first_en_cyc < 0) first_en_cyc = cyc_now;
                if (!mute) begin
                    pend = 1; orphan = 0; cnt = L;
                    rp = alu_P; rq = alu_Q; rop = alu_op;
                    res = alu_fn(alu_op, alu_P, alu_Q);
                end
            end
        end
    end

    // Pulse start and wait (bounded) for done; optionally re-pulse start mid-run
    task automatic do_mult(input logic [KW-1:0] kk, input logic [128:0] gg, input bit mid,
                           output logic [128:0] r, output logic e, output int bcyc,
                           output int done_cyc, output bit ok);
        op_log.delete();
        first_en_cyc = -1;
        k = kk; G = gg; start = 1;
        @(posedge clk); #1;
        start = 0;
        bcyc = 0; ok = 0; r = 'x; e = 'x; done_cyc = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (busy) bcyc++;
            if (done) begin
                ok = 1; r = R_out; e = err; done_cyc = cyc_now;
            end else begin
                if (mid && bcyc == 20) begin
                    start = 1; k = 8'h01; G = mkpt(64'd5, 64'd5);
                end else begin
                    start = 0;
                end
                @(posedge clk); #1;
            end
        end
        start = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL done_timeout: got no done within bound want done pulse (k=%0d)", kk);
        end
    endtask

    task automatic check_ops(input string nm, input logic [KW-1:0] kk);
        logic [1:0] exp_q[$];
        int m;
        m = -1;
        for (int i = 0; i < KW; i++) if (kk[i]) m = i;
        for (int i = m - 1; i >= 0; i--) begin
            exp_q.push_back(OP_DBL);
            if (kk[i]) exp_q.push_back(OP_ADD);
        end
        total++;
        if (op_log.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_op_count: got %0d want %0d", nm, op_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (op_log[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s_op_seq[%0d]: got %0d want %0d", nm, i, op_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 0; start = 0; k = '0; G = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, alu_en} !== 4'b0 || alu_op !== 2'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got busy=%b done=%b err=%b en=%b op=%0d want all 0",
                     busy, done, err, alu_en, alu_op);
        end
        total++;
        if (alu_P !== '0 || alu_Q !== '0) begin
            bad++;
            $display("FAIL reset_operands: got P=%h Q=%h want 0", alu_P, alu_Q);
        end
        total++;
        if (R_out !== INF) begin
            bad++;
            $display("FAIL reset_rout: got %h want %h", R_out, INF);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input string nm, input logic [KW-1:0] kk, input logic [128:0] gg,
                              input logic [128:0] want, input bit mid);
        logic [128:0] r;
        logic e;
        int bc, dc, calls;
        bit ok;
        do_mult(kk, gg, mid, r, e, bc, dc, ok);
        calls = ref_calls(kk);
        total++;
        if (r !== want) begin
            bad++;
            $display("FAIL %s_result: got %h want %h", nm, r, want);
        end
        total++;
        if (e !== 1'b0) begin
            bad++;
            $display("FAIL %s_err: got %b want 0", nm, e);
        end
        total++;
        if (bc != KW + calls * (L + 1) + 1) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", nm, bc, KW + calls * (L + 1) + 1);
        end
        check_ops(nm, kk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [KW-1:0] kk;
        logic [128:0]  gg;
        for (int n = 0; n < 8; n++) begin
            kk = KW'($urandom_range(0, 255));
            gg = mkpt(64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)));
            test_basic("random", kk, gg, ref_mul(kk, gg), 0);
        end
    endtask

    task automatic test_timeout;
        logic [128:0] r;
        logic e;
        int bc, dc;
        bit ok;
        mute = 1;
        do_mult(8'd3, mkpt(64'd93, 64'd9), 0, r, e, bc, dc, ok);
        total++;
        if (r !== INF || e !== 1'b1) begin
            bad++;
            $display("FAIL timeout_result: got R=%h err=%b want R=%h err=1", r, e, INF);
        end
        total++;
        if (dc - first_en_cyc != TIMEOUT + 1) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d want %0d", dc - first_en_cyc, TIMEOUT + 1);
        end
        mute = 0;
        force_done = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || R_out !== INF) begin
                bad++;
                $display("FAIL late_done_ignored: got done=%b busy=%b R=%h want 0 0 %h", done, busy, R_out, INF);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 0;
        op_log.delete();
        first_en_cyc = -1;
        k = 8'd13; G = mkpt(64'd93, 64'd9); start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (alu_en && alu_op == OP_ADD) seen = 1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_add_req: got no ADD request want one");
        end
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        total++;
        if (alu_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_immediate: got en=%b busy=%b done=%b want 0 0 0", alu_en, busy, done);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL rst_stale_done: got busy=%b done=%b want 0 0", busy, done);
            end
        end
        test_basic("after_rst", 8'd2, mkpt(64'd93, 64'd9), mkpt(64'd186, 64'd18), 0);
    endtask

    initial begin
        test_reset();
        test_basic("k0", 8'd0, mkpt(64'd93, 64'd9), INF, 0);
        test_basic("k1", 8'd1, mkpt(64'd93, 64'd9), mkpt(64'd93, 64'd9), 0);
        test_basic("k13", 8'd13, mkpt(64'd93, 64'd9), mkpt(64'd1209, 64'd117), 0);
        test_basic("k255_mid", 8'd255, mkpt(64'd8626, 64'd39), mkpt(64'd2199630, 64'd9945), 1);
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
